// File: rtl/fetch_if.sv
// Bus between the fetch stage and its neighbours: debug-unit imem loading,
// decode redirects/stall/halt, and the IF/ID outputs consumed by decode.
interface fetch_if #(
    parameter int NB_DATA = 32,
    parameter int NB_PC   = 7
);
    logic               imem_wr_en_i;
    logic [NB_PC-1:0]   imem_wr_addr_i;
    logic [NB_DATA-1:0] imem_wr_data_i;
    logic               start_i;
    logic               enable_i;
    logic               stall_i;
    logic               pc_branch_or_jump_i;
    logic [1:0]         pc_src_i;
    logic [NB_PC-1:0]   address_branch_i;
    logic [NB_PC-1:0]   address_jump_i;
    logic [NB_PC-1:0]   address_register_i;
    logic               halt_i;
    logic [NB_DATA-1:0] instruction_o;
    logic [NB_PC-1:0]   pc_decode_o;
    logic [NB_PC-1:0]   pc_o;
    logic               halted_o;

    modport master (
        output imem_wr_en_i, imem_wr_addr_i, imem_wr_data_i, start_i, enable_i,
               stall_i, pc_branch_or_jump_i, pc_src_i, address_branch_i,
               address_jump_i, address_register_i, halt_i,
        input  instruction_o, pc_decode_o, pc_o, halted_o
    );

    modport slave (
        input  imem_wr_en_i, imem_wr_addr_i, imem_wr_data_i, start_i, enable_i,
               stall_i, pc_branch_or_jump_i, pc_src_i, address_branch_i,
               address_jump_i, address_register_i, halt_i,
        output instruction_o, pc_decode_o, pc_o, halted_o
    );
endinterface

// File: rtl/fetch_top.sv
// Instruction-fetch stage with its IF/ID pipeline register. Holds the PC and a
// debug-loaded instruction memory; follows decode's redirects, stall and halt.
module fetch_top #(
    parameter int NB_DATA   = 32,
    parameter int NB_PC     = 7,
    parameter int IMEM_SIZE = 128
) (
    input logic   clock_i,
    input logic   reset_i,
    fetch_if.slave bus
);
    typedef enum logic [1:0] {LOAD, RUN, HALTED} state_t;

    state_t             state_q, state_d;
    logic [NB_PC-1:0]   pc_q, pc_d;
    logic [NB_PC-1:0]   pc_decode_q, pc_decode_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic               halted_q, halted_d;

    logic [NB_DATA-1:0] imem [IMEM_SIZE];
    logic [NB_DATA-1:0] fetch_word;
    logic [NB_PC-1:0]   pc_inc;
    logic [NB_PC-1:0]   redirect_target;
    logic               redirect;

    assign fetch_word = imem[pc_q];
    assign pc_inc     = pc_q + NB_PC'(1);
    assign redirect   = bus.pc_branch_or_jump_i && (bus.pc_src_i != 2'b00);

    always_comb begin
        redirect_target = bus.address_register_i;
        case (bus.pc_src_i)
            2'b01:   redirect_target = bus.address_branch_i;
            2'b10:   redirect_target = bus.address_jump_i;
            default: redirect_target = bus.address_register_i;
        endcase
    end

    // Priority within RUN: halt, then stall, then redirect, then sequential fetch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_decode_d = pc_decode_q;
        instr_d     = instr_q;
        halted_d    = halted_q;
        case (state_q)
            LOAD: begin
                pc_d        = '0;
                pc_decode_d = '0;
                instr_d     = '0;
                halted_d    = 1'b0;
                if (bus.start_i) state_d = RUN;
            end
            RUN: begin
                if (bus.enable_i) begin
                    if (bus.halt_i) begin
                        instr_d     = '0;
                        pc_decode_d = '0;
                        halted_d    = 1'b1;
                        state_d     = HALTED;
                    end else if (bus.stall_i) begin
                        pc_d = pc_q;
                    end else if (redirect) begin
                        pc_d        = redirect_target;
                        instr_d     = '0;
                        pc_decode_d = '0;
                    end else begin
                        pc_d        = pc_inc;
                        instr_d     = fetch_word;
                        pc_decode_d = pc_inc;
                    end
                end
            end
            HALTED: begin
                instr_d     = '0;
                pc_decode_d = '0;
                halted_d    = 1'b1;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= LOAD;
            pc_q        <= '0;
            pc_decode_q <= '0;
            instr_q     <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_decode_q <= pc_decode_d;
            instr_q     <= instr_d;
            halted_q    <= halted_d;
        end
    end

    // Memory contents survive reset so a program can be rerun without reloading.
    always_ff @(posedge clock_i) begin
        if (state_q == LOAD && bus.imem_wr_en_i) begin
            imem[bus.imem_wr_addr_i] <= bus.imem_wr_data_i;
        end
    end

    assign bus.instruction_o = instr_q;
    assign bus.pc_decode_o   = pc_decode_q;
    assign bus.pc_o          = pc_q;
    assign bus.halted_o      = halted_q;
endmodule
